// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: merges the core's instruction and data request ports onto one
// shared memory bus, holds the grant across bus stalls, and returns in-order read
// responses to whichever side issued each read.
// MAX_OUTSTANDING must be a power of two and at least 2.
module core_mem_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DRAM_PRIORITY   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  // instruction side
  input  logic                               iram_req_i,
  input  logic                               iram_write_i,
  input  logic [XLEN/8-1:0]                  iram_wstrb_i,
  input  logic [XLEN-1:0]                    iram_addr_i,
  input  logic [XLEN-1:0]                    iram_wdata_i,
  output logic                               iram_ready_o,
  output logic                               iram_rvalid_o,
  output logic [XLEN-1:0]                    iram_rdata_o,
  // data side
  input  logic                               dram_req_i,
  input  logic                               dram_write_i,
  input  logic [XLEN/8-1:0]                  dram_wstrb_i,
  input  logic [XLEN-1:0]                    dram_addr_i,
  input  logic [XLEN-1:0]                    dram_wdata_i,
  output logic                               dram_ready_o,
  output logic                               dram_rvalid_o,
  output logic [XLEN-1:0]                    dram_rdata_o,
  // shared bus
  output logic                               bus_req_o,
  output logic                               bus_write_o,
  output logic [XLEN/8-1:0]                  bus_wstrb_o,
  output logic [XLEN-1:0]                    bus_addr_o,
  output logic [XLEN-1:0]                    bus_wdata_o,
  input  logic                               bus_ready_i,
  input  logic                               bus_rvalid_i,
  input  logic [XLEN-1:0]                    bus_rdata_i,
  // status
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_stray_rvalid_o
);

  localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STRB_W = XLEN / 8;

  // Source ids as stored in the order FIFO
  localparam logic SRC_IRAM = 1'b0;
  localparam logic SRC_DRAM = 1'b1;

  // Order FIFO: one bit per in-flight read naming the side that issued it
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  // Grant hold across stalls, round-robin pointer, sticky stray-response flag
  logic lock_q, lock_d;
  logic lock_src_q, lock_src_d;
  logic rr_q, rr_d;
  logic err_q, err_d;

  logic              gnt_src;
  logic              gnt_req;
  logic              gnt_write;
  logic              fifo_full;
  logic              fifo_empty;
  logic              blocked;
  logic              accept;
  logic              push;
  logic              pop;
  logic              head_src;

  // Grant selection: a held grant wins, then a lone requestor, then the tie-break
  always_comb begin
    gnt_src = SRC_IRAM;
    if (lock_q) begin
      gnt_src = lock_src_q;
    end else if (iram_req_i && dram_req_i) begin
      gnt_src = (DRAM_PRIORITY != 0) ? SRC_DRAM : rr_q;
    end else if (dram_req_i) begin
      gnt_src = SRC_DRAM;
    end else begin
      gnt_src = SRC_IRAM;
    end
  end

  // Route the granted request onto the bus; a read is held off while the FIFO is full
  always_comb begin
    gnt_req     = iram_req_i;
    gnt_write   = iram_write_i;
    bus_wstrb_o = iram_wstrb_i;
    bus_addr_o  = iram_addr_i;
    bus_wdata_o = iram_wdata_i;
    if (gnt_src == SRC_DRAM) begin
      gnt_req     = dram_req_i;
      gnt_write   = dram_write_i;
      bus_wstrb_o = dram_wstrb_i;
      bus_addr_o  = dram_addr_i;
      bus_wdata_o = dram_wdata_i;
    end
    bus_write_o = gnt_write;

    // Full check uses the registered count so a same-cycle pop cannot free a slot
    fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    fifo_empty = (count_q == '0);
    blocked    = !gnt_write && fifo_full;

    bus_req_o    = gnt_req && !blocked && !rst;
    accept       = bus_req_o && bus_ready_i;
    iram_ready_o = accept && (gnt_src == SRC_IRAM);
    dram_ready_o = accept && (gnt_src == SRC_DRAM);
    push         = accept && !gnt_write;
  end

  // Response routing: the FIFO head names the owner of each in-order response
  always_comb begin
    pop           = bus_rvalid_i && !fifo_empty && !rst;
    head_src      = fifo_q[rd_ptr_q];
    iram_rvalid_o = pop && (head_src == SRC_IRAM);
    dram_rvalid_o = pop && (head_src == SRC_DRAM);
    iram_rdata_o  = bus_rdata_i;
    dram_rdata_o  = bus_rdata_i;
  end

  // Next-state for the order FIFO, grant hold, round-robin pointer and error flag
  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    rr_d       = rr_q;
    err_d      = err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = gnt_src;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (accept) begin
      lock_d = 1'b0;
      rr_d   = ~gnt_src;
    end else if (bus_req_o) begin
      lock_d     = 1'b1;
      lock_src_d = gnt_src;
    end

    if (bus_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous reset; in-flight reads are forgotten on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_IRAM;
      rr_q       <= SRC_IRAM;
      err_q      <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
    end
  end

  assign outstanding_o      = count_q;
  assign err_stray_rvalid_o = err_q;

  // A stalled requestor must keep its request up and its fields unchanged
  property p_stall_stable;
    @(posedge clk) disable iff (rst)
      (bus_req_o && !bus_ready_i) |=>
        (bus_req_o && $stable(bus_write_o) && $stable(bus_addr_o) &&
         $stable(bus_wstrb_o) && $stable(bus_wdata_o));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

  // Keeps the strobe width constant referenced for readers sizing external buses
  logic [STRB_W-1:0] unused_strb_w;
  assign unused_strb_w = bus_wstrb_o;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: one DUT with data-side priority and one with
// round-robin share the same stimulus; both are checked every cycle against a
// queue-based model, with directed scenarios followed by a random phase.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iram_req, iram_write, dram_req, dram_write;
  logic [3:0]  iram_wstrb, dram_wstrb;
  logic [31:0] iram_addr, iram_wdata, dram_addr, dram_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  logic        iram_ready_w[2], iram_rvalid_w[2], dram_ready_w[2], dram_rvalid_w[2];
  logic [31:0] iram_rdata_w[2], dram_rdata_w[2];
  logic        bus_req_w[2], bus_write_w[2];
  logic [3:0]  bus_wstrb_w[2];
  logic [31:0] bus_addr_w[2], bus_wdata_w[2];
  logic [2:0]  outst_w[2];
  logic        err_w[2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.XLEN(32), .MAX_OUTSTANDING(4), .DRAM_PRIORITY(1)) u_dut_prio (
    .clk(clk), .rst(rst),
    .iram_req_i(iram_req), .iram_write_i(iram_write), .iram_wstrb_i(iram_wstrb),
    .iram_addr_i(iram_addr), .iram_wdata_i(iram_wdata),
    .iram_ready_o(iram_ready_w[0]), .iram_rvalid_o(iram_rvalid_w[0]), .iram_rdata_o(iram_rdata_w[0]),
    .dram_req_i(dram_req), .dram_write_i(dram_write), .dram_wstrb_i(dram_wstrb),
    .dram_addr_i(dram_addr), .dram_wdata_i(dram_wdata),
    .dram_ready_o(dram_ready_w[0]), .dram_rvalid_o(dram_rvalid_w[0]), .dram_rdata_o(dram_rdata_w[0]),
    .bus_req_o(bus_req_w[0]), .bus_write_o(bus_write_w[0]), .bus_wstrb_o(bus_wstrb_w[0]),
    .bus_addr_o(bus_addr_w[0]), .bus_wdata_o(bus_wdata_w[0]),
    .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .outstanding_o(outst_w[0]), .err_stray_rvalid_o(err_w[0])
  );

  core_mem_arbiter #(.XLEN(32), .MAX_OUTSTANDING(4), .DRAM_PRIORITY(0)) u_dut_rr (
    .clk(clk), .rst(rst),
    .iram_req_i(iram_req), .iram_write_i(iram_write), .iram_wstrb_i(iram_wstrb),
    .iram_addr_i(iram_addr), .iram_wdata_i(iram_wdata),
    .iram_ready_o(iram_ready_w[1]), .iram_rvalid_o(iram_rvalid_w[1]), .iram_rdata_o(iram_rdata_w[1]),
    .dram_req_i(dram_req), .dram_write_i(dram_write), .dram_wstrb_i(dram_wstrb),
    .dram_addr_i(dram_addr), .dram_wdata_i(dram_wdata),
    .dram_ready_o(dram_ready_w[1]), .dram_rvalid_o(dram_rvalid_w[1]), .dram_rdata_o(dram_rdata_w[1]),
    .bus_req_o(bus_req_w[1]), .bus_write_o(bus_write_w[1]), .bus_wstrb_o(bus_wstrb_w[1]),
    .bus_addr_o(bus_addr_w[1]), .bus_wdata_o(bus_wdata_w[1]),
    .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .outstanding_o(outst_w[1]), .err_stray_rvalid_o(err_w[1])
  );

  // Reference model: per DUT, a queue of issuing sides plus hold/rr/error state
  bit mq0[$];
  bit mq1[$];
  bit m_lock[2], m_lsrc[2], m_rr[2], m_err[2];
  bit e_g[2], e_wr[2], e_breq[2], e_acc[2], e_pop[2], e_head[2];

  function automatic int qsz(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic bit qhead(input int k);
    if (k == 0) return mq0[0];
    return mq1[0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic predict(input int k);
    bit g;
    bit prio;
    prio = (k == 0);
    if (m_lock[k]) g = m_lsrc[k];
    else if (iram_req && dram_req) g = prio ? 1'b1 : m_rr[k];
    else g = dram_req;
    e_g[k]    = g;
    e_wr[k]   = g ? dram_write : iram_write;
    e_breq[k] = !rst && (g ? dram_req : iram_req) && (e_wr[k] || qsz(k) < 4);
    e_acc[k]  = e_breq[k] && bus_ready;
    e_pop[k]  = !rst && bus_rvalid && (qsz(k) > 0);
    e_head[k] = e_pop[k] ? qhead(k) : 1'b0;
  endtask

  task automatic compare(input int k);
    check($sformatf("bus_req%0d", k), 64'(bus_req_w[k]), 64'(e_breq[k]));
    if (e_breq[k]) begin
      check($sformatf("bus_write%0d", k), 64'(bus_write_w[k]), 64'(e_wr[k]));
      check($sformatf("bus_addr%0d", k), 64'(bus_addr_w[k]), 64'(e_g[k] ? dram_addr : iram_addr));
      check($sformatf("bus_wdata%0d", k), 64'(bus_wdata_w[k]), 64'(e_g[k] ? dram_wdata : iram_wdata));
      check($sformatf("bus_wstrb%0d", k), 64'(bus_wstrb_w[k]), 64'(e_g[k] ? dram_wstrb : iram_wstrb));
    end
    check($sformatf("iram_ready%0d", k), 64'(iram_ready_w[k]), 64'(e_acc[k] && !e_g[k]));
    check($sformatf("dram_ready%0d", k), 64'(dram_ready_w[k]), 64'(e_acc[k] && e_g[k]));
    check($sformatf("iram_rvalid%0d", k), 64'(iram_rvalid_w[k]), 64'(e_pop[k] && !e_head[k]));
    check($sformatf("dram_rvalid%0d", k), 64'(dram_rvalid_w[k]), 64'(e_pop[k] && e_head[k]));
    if (e_pop[k] && !e_head[k])
      check($sformatf("iram_rdata%0d", k), 64'(iram_rdata_w[k]), 64'(bus_rdata));
    if (e_pop[k] && e_head[k])
      check($sformatf("dram_rdata%0d", k), 64'(dram_rdata_w[k]), 64'(bus_rdata));
    if (!rst) begin
      check($sformatf("outstanding%0d", k), 64'(outst_w[k]), 64'(qsz(k)));
      check($sformatf("err_stray%0d", k), 64'(err_w[k]), 64'(m_err[k]));
    end
  endtask

  task automatic update(input int k);
    if (rst) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      m_lock[k] = 1'b0;
      m_rr[k]   = 1'b0;
      m_err[k]  = 1'b0;
    end else begin
      if (bus_rvalid && !e_pop[k]) m_err[k] = 1'b1;
      if (e_pop[k]) begin
        if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (e_acc[k] && !e_wr[k]) begin
        if (k == 0) mq0.push_back(e_g[k]); else mq1.push_back(e_g[k]);
      end
      if (e_acc[k]) begin
        m_lock[k] = 1'b0;
        m_rr[k]   = !e_g[k];
      end else if (e_breq[k]) begin
        m_lock[k] = 1'b1;
        m_lsrc[k] = e_g[k];
      end
    end
  endtask

  task automatic settle();
    #1;
    for (int k = 0; k < 2; k++) begin
      predict(k);
      compare(k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) update(k);
    #1;
  endtask

  task automatic drv_i(input bit rq, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    iram_req = rq; iram_write = wr; iram_addr = a; iram_wdata = d; iram_wstrb = s;
  endtask

  task automatic drv_d(input bit rq, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    dram_req = rq; dram_write = wr; dram_addr = a; dram_wdata = d; dram_wstrb = s;
  endtask

  task automatic drv_bus(input bit rdy, input bit rv, input logic [31:0] rd);
    bus_ready = rdy; bus_rvalid = rv; bus_rdata = rd;
  endtask

  initial begin
    bit hold_i, hold_d;

    // Reset
    rst = 1'b1;
    drv_i(0, 0, 0, 0, 0); drv_d(0, 0, 0, 0, 0); drv_bus(0, 0, 0);
    settle(); tick();
    settle(); tick();
    rst = 1'b0;
    settle();
    check("reset_outstanding", 64'(outst_w[0]), 64'd0);
    check("reset_err", 64'(err_w[0]), 64'd0);
    tick();

    // Lone instruction read, then its response
    drv_i(1, 0, 32'h100, 32'h0, 4'hF); drv_bus(1, 0, 0);
    settle();
    check("t1_addr", 64'(bus_addr_w[0]), 64'h100);
    check("t1_iready", 64'(iram_ready_w[0]), 64'd1);
    tick();
    drv_i(0, 0, 0, 0, 0); drv_bus(1, 1, 32'hDEAD);
    settle();
    check("t1_rvalid", 64'(iram_rvalid_w[0]), 64'd1);
    check("t1_rdata", 64'(iram_rdata_w[0]), 64'hDEAD);
    tick();

    // Simultaneous reads: data side first, then instruction; responses in issue order
    drv_bus(1, 0, 0);
    drv_i(1, 0, 32'h200, 32'h0, 4'hF); drv_d(1, 0, 32'h300, 32'h0, 4'hF);
    settle();
    check("t2_first_addr", 64'(bus_addr_w[0]), 64'h300);
    check("t2_first_dready", 64'(dram_ready_w[0]), 64'd1);
    check("t2_first_iready", 64'(iram_ready_w[0]), 64'd0);
    tick();
    drv_d(0, 0, 0, 0, 0);
    settle();
    check("t2_second_addr", 64'(bus_addr_w[0]), 64'h200);
    tick();
    drv_i(0, 0, 0, 0, 0); drv_bus(1, 1, 32'h3333);
    settle();
    check("t2_resp_dram", 64'(dram_rvalid_w[0]), 64'd1);
    tick();
    drv_bus(1, 1, 32'h2222);
    settle();
    check("t2_resp_iram", 64'(iram_rvalid_w[0]), 64'd1);
    tick();

    // Stall with data side granted; instruction side arrives mid-stall
    drv_bus(0, 0, 0); drv_d(1, 0, 32'h400, 32'h0, 4'hF);
    settle(); tick();
    drv_i(1, 0, 32'h500, 32'h0, 4'hF);
    for (int n = 0; n < 2; n++) begin
      settle();
      check("t3_addr_stable", 64'(bus_addr_w[0]), 64'h400);
      check("t3_iready_low", 64'(iram_ready_w[0]), 64'd0);
      tick();
    end
    drv_bus(1, 0, 0);
    settle();
    check("t3_dram_accept", 64'(dram_ready_w[0]), 64'd1);
    tick();
    drv_d(0, 0, 0, 0, 0);
    settle();
    check("t3_iram_next", 64'(iram_ready_w[0]), 64'd1);
    tick();
    drv_i(0, 0, 0, 0, 0); drv_bus(1, 1, 32'h4444);
    settle(); tick();
    drv_bus(1, 1, 32'h5555);
    settle(); tick();
    drv_bus(1, 0, 0);

    // Fill the order FIFO; a further read blocks, a write still passes
    for (int n = 0; n < 4; n++) begin
      drv_i(1, 0, 32'h1000 + 32'(n) * 32'd4, 32'h0, 4'hF);
      settle(); tick();
    end
    drv_i(1, 0, 32'h1010, 32'h0, 4'hF);
    settle();
    check("t4_blocked", 64'(bus_req_w[0]), 64'd0);
    check("t4_outstanding", 64'(outst_w[0]), 64'd4);
    tick();
    drv_i(0, 0, 0, 0, 0); drv_d(1, 1, 32'h2000, 32'hCAFE, 4'h3);
    settle();
    check("t4_write_req", 64'(bus_req_w[0]), 64'd1);
    check("t4_write_ready", 64'(dram_ready_w[0]), 64'd1);
    tick();
    drv_d(0, 0, 0, 0, 0);

    // Drain to two, then pop and push in the same cycle
    drv_bus(1, 1, 32'hA0); settle(); tick();
    drv_bus(1, 1, 32'hA1); settle(); tick();
    drv_bus(1, 1, 32'hABC); drv_i(1, 0, 32'h3000, 32'h0, 4'hF);
    settle();
    check("t5_pre", 64'(outst_w[0]), 64'd2);
    tick();
    drv_i(0, 0, 0, 0, 0); drv_bus(1, 0, 0);
    settle();
    check("t5_post", 64'(outst_w[0]), 64'd2);
    tick();
    drv_bus(1, 1, 32'hB0); settle(); tick();
    drv_bus(1, 1, 32'hB1); settle(); tick();

    // Stray response with nothing outstanding
    drv_bus(1, 1, 32'hBAD);
    settle();
    check("t6_no_irvalid", 64'(iram_rvalid_w[0]), 64'd0);
    check("t6_no_drvalid", 64'(dram_rvalid_w[0]), 64'd0);
    tick();
    drv_bus(1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      settle();
      check("t6_err_sticky", 64'(err_w[0]), 64'd1);
      tick();
    end
    rst = 1'b1; settle(); tick(); rst = 1'b0;
    settle();
    check("t6_err_cleared", 64'(err_w[0]), 64'd0);
    tick();

    // Random traffic; a stalled side keeps its request and fields until accepted
    for (int c = 0; c < 3000; c++) begin
      hold_i = (m_lock[0] && !m_lsrc[0]) || (m_lock[1] && !m_lsrc[1]);
      hold_d = (m_lock[0] && m_lsrc[0]) || (m_lock[1] && m_lsrc[1]);
      if (!hold_i)
        drv_i(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom, $urandom,
              4'($urandom));
      if (!hold_d)
        drv_d(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom, $urandom,
              4'($urandom));
      drv_bus(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0), $urandom);
      rst = ($urandom_range(0, 199) == 0);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
